// File: rtl/mmu_xlate_arbiter.sv
// Arbitrates inst/data translation requests onto one fixed-segment translator with a
// one-entry output buffer. Optional inst starvation guard: define MMU_ARB_FAIRNESS_EN.
module mmu_xlate_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    input  logic [31:0] inst_vaddr,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic [31:0] data_vaddr,
    input  logic        data_wr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_paddr,
    output logic        out_uncached,
    output logic        out_src,
    output logic        out_wr
);

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [AW-1:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [AW-1:0] KSEG2_BASE = 32'hC000_0000;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          can_accept;
    logic          grant_data;
    logic          grant_inst;
    logic          accept;
    logic          force_inst;
    logic [AW-1:0] sel_vaddr;
    logic [AW-1:0] xl_paddr;
    logic          xl_uncached;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("STARVE_LIMIT must be >= 1 and fit in CNT_W bits");
    end

`ifdef MMU_ARB_FAIRNESS_EN
    logic [CNT_W-1:0] starve_cnt;

    assign force_inst = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts consecutive cycles inst waited; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!inst_req_valid || inst_req_ready) begin
            starve_cnt <= '0;
        end else if (!force_inst) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign force_inst = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush dominates everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (accept) begin
            state_nxt = FULL;
        end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    // Output/grant logic: readies depend on the other side's valid, never on a loop
    always_comb begin
        can_accept     = ~flush & ((state == EMPTY) | out_ready);
        grant_data     = data_req_valid & ~(force_inst & inst_req_valid);
        grant_inst     = inst_req_valid & ~grant_data;
        data_req_ready = can_accept & grant_data;
        inst_req_ready = can_accept & grant_inst;
        accept         = data_req_ready | inst_req_ready;
    end

    // Fixed-segment translation of the granted address
    always_comb begin
        sel_vaddr   = grant_data ? data_vaddr : inst_vaddr;
        xl_paddr    = sel_vaddr;
        xl_uncached = 1'b0;
        if (sel_vaddr >= KSEG1_BASE && sel_vaddr < KSEG2_BASE) begin
            xl_paddr    = sel_vaddr - KSEG1_BASE;
            xl_uncached = 1'b1;
        end else if (sel_vaddr >= KSEG0_BASE && sel_vaddr < KSEG1_BASE) begin
            xl_paddr = sel_vaddr - KSEG0_BASE;
        end
    end

    // Output buffer payload, loaded only on accept so it holds during stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_paddr    <= '0;
            out_uncached <= 1'b0;
            out_src      <= 1'b0;
            out_wr       <= 1'b0;
        end else if (accept) begin
            out_paddr    <= xl_paddr;
            out_uncached <= xl_uncached;
            out_src      <= grant_data;
            out_wr       <= grant_data & data_wr;
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mmu_xlate_arbiter.sv
// Scoreboard bench for mmu_xlate_arbiter: directed stimulus pushes expected results,
// a negedge monitor pops and compares on each consumed or flushed buffer entry.
module tb_mmu_xlate_arbiter;

    typedef struct packed {
        logic [31:0] pa;
        logic        unc;
        logic        src;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req_valid = 1'b0;
    logic        inst_req_ready;
    logic [31:0] inst_vaddr = '0;
    logic        data_req_valid = 1'b0;
    logic        data_req_ready;
    logic [31:0] data_vaddr = '0;
    logic        data_wr = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_paddr;
    logic        out_uncached;
    logic        out_src;
    logic        out_wr;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [31:0] sw_va  [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h9FFF_FFFF,
                                32'hA000_0000, 32'hBFFF_FFFF, 32'hC000_0000};
    logic [31:0] sw_pa  [6] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h1FFF_FFFF,
                                32'h0000_0000, 32'h1FFF_FFFF, 32'hC000_0000};
    logic        sw_unc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    mmu_xlate_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_vaddr     (inst_vaddr),
        .data_req_valid (data_req_valid),
        .data_req_ready (data_req_ready),
        .data_vaddr     (data_vaddr),
        .data_wr        (data_wr),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_paddr      (out_paddr),
        .out_uncached   (out_uncached),
        .out_src        (out_src),
        .out_wr         (out_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pa, input logic unc, input logic src, input logic wr);
        sb.push_back(exp_t'({pa, unc, src, wr}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an entry leaves the buffer when consumed or discarded by flush
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && (out_ready || flush)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h/%b/%b/%b required=none",
                         out_paddr, out_uncached, out_src, out_wr);
            end else begin
                e = sb.pop_front();
                if ({out_paddr, out_uncached, out_src, out_wr} !== e) begin
                    errors++;
                    $display("FAIL out_entry actual=%h/%b/%b/%b required=%h/%b/%b/%b",
                             out_paddr, out_uncached, out_src, out_wr,
                             e.pa, e.unc, e.src, e.wr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_inst;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_paddr", out_paddr, 32'd0);
        chk("rst_out_uncached", 32'(out_uncached), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_wr", 32'(out_wr), 32'd0);
        rst = 1'b0;

        // 1: both valid, data first then inst
        inst_req_valid = 1'b1; inst_vaddr = 32'hBFC0_0000;
        data_req_valid = 1'b1; data_vaddr = 32'h8000_1000; data_wr = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t1_data_ready", 32'(data_req_ready), 32'd1);
        chk("t1_inst_ready_blocked", 32'(inst_req_ready), 32'd0);
        push(32'h0000_1000, 1'b0, 1'b1, 1'b1);
        tick();
        data_req_valid = 1'b0; data_wr = 1'b0;
        #1;
        chk("t1_inst_ready", 32'(inst_req_ready), 32'd1);
        chk("t1_out_valid_lat1", 32'(out_valid), 32'd1);
        push(32'h1FC0_0000, 1'b1, 1'b0, 1'b0);
        tick();
        inst_req_valid = 1'b0;
        tick();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 2: boundary sweep on the inst side, back-to-back
        for (int i = 0; i < 6; i++) begin
            inst_req_valid = 1'b1; inst_vaddr = sw_va[i];
            #1;
            chk("t2_inst_ready", 32'(inst_req_ready), 32'd1);
            push(sw_pa[i], sw_unc[i], 1'b0, 1'b0);
            tick();
        end
        inst_req_valid = 1'b0;
        tick();
        tick();

        // 3: stall with pending requests, then release
        data_req_valid = 1'b1; data_vaddr = 32'h0000_0040; out_ready = 1'b0;
        #1;
        chk("t3_fill_ready", 32'(data_req_ready), 32'd1);
        push(32'h0000_0040, 1'b0, 1'b1, 1'b0);
        tick();
        data_vaddr = 32'h0000_0080;
        inst_req_valid = 1'b1; inst_vaddr = 32'h8000_2000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_data_ready", 32'(data_req_ready), 32'd0);
            chk("t3_stall_inst_ready", 32'(inst_req_ready), 32'd0);
            chk("t3_stall_paddr", out_paddr, 32'h0000_0040);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_data_ready", 32'(data_req_ready), 32'd1);
        push(32'h0000_0080, 1'b0, 1'b1, 1'b0);
        tick();
        data_req_valid = 1'b0;
        #1;
        chk("t3_inst_ready", 32'(inst_req_ready), 32'd1);
        push(32'h0000_2000, 1'b0, 1'b0, 1'b0);
        tick();
        inst_req_valid = 1'b0;
        tick();
        tick();

        // 4: flush while full with a pending data request
        data_req_valid = 1'b1; data_vaddr = 32'h0000_0100; out_ready = 1'b0;
        #1;
        push(32'h0000_0100, 1'b0, 1'b1, 1'b0);
        tick();
        data_vaddr = 32'h0000_0200; flush = 1'b1;
        #1;
        chk("t4_flush_data_ready", 32'(data_req_ready), 32'd0);
        chk("t4_flush_inst_ready", 32'(inst_req_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("t4_after_flush_valid", 32'(out_valid), 32'd0);
        chk("t4_resume_data_ready", 32'(data_req_ready), 32'd1);
        push(32'h0000_0200, 1'b0, 1'b1, 1'b0);
        tick();
        data_req_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("t4_resume_valid", 32'(out_valid), 32'd1);
        tick();
        tick();

        // 5: both valid continuously; grant order depends on fairness guard
        inst_req_valid = 1'b1; inst_vaddr = 32'hA000_1000;
        data_req_valid = 1'b1; data_vaddr = 32'h0000_3000; data_wr = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
`ifdef MMU_ARB_FAIRNESS_EN
            exp_inst = ((i % 5) == 4);
`else
            exp_inst = 1'b0;
`endif
            #1;
            chk("t5_inst_grant", 32'(inst_req_ready), 32'(exp_inst));
            chk("t5_data_grant", 32'(data_req_ready), 32'(!exp_inst));
            if (exp_inst) push(32'h0000_1000, 1'b1, 1'b0, 1'b0);
            else          push(32'h0000_3000, 1'b0, 1'b1, 1'b1);
            tick();
        end
        inst_req_valid = 1'b0; data_req_valid = 1'b0; data_wr = 1'b0;
        tick();
        tick();

        // 6: async reset while full and mid-handshake
        data_req_valid = 1'b1; data_vaddr = 32'h9000_0000; out_ready = 1'b0;
        #1;
        push(32'h1000_0000, 1'b0, 1'b1, 1'b0);
        tick();
        out_ready = 1'b1; data_vaddr = 32'h0000_0500;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_paddr", out_paddr, 32'd0);
        chk("t6_async_src", 32'(out_src), 32'd0);
        sb.delete();
        data_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        data_req_valid = 1'b1; data_vaddr = 32'hC000_0000;
        #1;
        chk("t6_post_rst_ready", 32'(data_req_ready), 32'd1);
        chk("t6_post_rst_valid_before", 32'(out_valid), 32'd0);
        push(32'hC000_0000, 1'b0, 1'b1, 1'b0);
        tick();
        data_req_valid = 1'b0;
        #1;
        chk("t6_post_rst_valid_lat1", 32'(out_valid), 32'd1);
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
